pipe_ctl: RTL and testbench
===========================

Name: pipe_ctl

Overview:
- Central hazard and sequencing controller for the five-stage core.
- Produces every per-stage stall/clear pair: IF/ID, ID/EX (the stall/clear into the execute stage), and EX/MA (the execute stage's output register).
- Arbitrates between trap redirect, data-memory wait, branch/jump redirect, multi-cycle EX ops and load-use hazards.
- Keeps two saturating performance counters.

Parameters:
- TRAP_HOLD, 2, cycles fetch is held after a trap before IF restarts (≥1)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of the instruction in EX
- ex_load  in  1  EX instruction is a load (io_ops load bit)
- ex_multi  in  1  EX instruction is multi-cycle (mul/div)
- ex_multi_done  in  1  multi-cycle unit result valid this cycle
- bj_en  in  1  branch/jump taken in EX
- trap_en  in  1  trap/xret taken in EX
- imem_busy  in  1  instruction fetch not yet returned
- dmem_busy  in  1  MA-stage memory access not complete
- stall_if  out  1  hold PC / fetch
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX register (execute-stage stall)
- stall_ma  out  1  hold EX/MA register
- clear_id  out  1  bubble IF/ID
- clear_ex  out  1  bubble ID/EX
- clear_ma  out  1  bubble EX/MA
- stall_cnt  out  CNT_W  cycles with stall_if high
- flush_cnt  out  CNT_W  redirects taken (bj or trap)

Behaviour:
- Output timing: stall/clear outputs are combinational from inputs plus registered state. Counters are registered.
- FSM states:
  - RUN
  - MULTI: EX multi-cycle op in flight
  - TRAP: post-trap hold, down-counter trap_cnt
- Reset (rst=1 at a clk edge):
  - state=RUN, trap_cnt=0, both counters 0.
  - While rst is high: clear_id=clear_ex=clear_ma=1 and all stalls 0.
  - Asserting rst mid-MULTI or mid-TRAP returns to RUN on the next edge with no residual hold.
- Priority, evaluated each cycle, highest first:
  1. trap_en (state RUN or MULTI):
     - clear_id=clear_ex=clear_ma=1; stalls 0.
     - Next state TRAP, trap_cnt=TRAP_HOLD-1.
     - flush_cnt+1.
     - An in-flight multi-cycle op is abandoned.
  2. TRAP:
     - stall_if=1, clear_id=1, other outputs 0.
     - trap_cnt decrements; at 0, next state is RUN.
     - bj_en and trap_en are ignored in this state.
  3. dmem_busy:
     - stall_if=stall_id=stall_ex=stall_ma=1, clears 0.
     - State is unchanged, including in MULTI.
     - bj_en is not acted on while stall_ex=1; jmp_br re-asserts it after release.
  4. bj_en (RUN):
     - clear_id=clear_ex=1; flush_cnt+1.
     - Overrides load-use and imem_busy.
     - bj_en with ex_multi=1 is illegal.
  5. MULTI, or RUN with ex_multi=1:
     - stall_if=stall_id=stall_ex=1, clear_ma=1.
     - RUN→MULTI on the entry cycle.
     - In MULTI with ex_multi_done=1: stalls 0, clear_ma=0, next state RUN.
     - ex_multi_done in the entry cycle is ignored; minimum latency is 2 cycles.
  6. Load-use:
     - Condition: ex_load && ex_rd!=0 && ((id_rs1_used && id_rs1==ex_rd) || (id_rs2_used && id_rs2==ex_rd)).
     - Response: stall_if=stall_id=1, clear_ex=1, exactly one cycle.
  7. imem_busy:
     - stall_if=1, clear_id=1. Younger stages keep draining.
- Clear and stall are never both asserted on the same stage.
- Counters:
  - stall_cnt increments on any cycle with stall_if=1 and rst=0.
  - Both counters saturate at all-ones and do not wrap.

Decomposition:
- pipe_pkg holds:
  - state enum {RUN, MULTI, TRAP}
  - typedef for the stall/clear vector
  - TRAP_HOLD default constant
- One sub-module, sat_counter (CNT_W, inc, rst, count), instantiated twice.
- Hazard comparison stays inline.

Test Plan:
- Reset mid-op: rst pulsed while in TRAP with trap_cnt=1 → next cycle state RUN, all stalls 0, counters 0.
- Load-use hazard: ex_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1 → stall_if=stall_id=clear_ex=1 for exactly 1 cycle, stall_cnt=1. Repeat with ex_rd=0 → no stall.
- Trap redirect: trap_en for 1 cycle with TRAP_HOLD=2 → cycle0 all clears=1; cycles 1–2 stall_if=1 and clear_id=1; cycle3 RUN; flush_cnt=1. A bj_en in cycle1 is ignored.
- Multi-cycle op: ex_multi=1, ex_multi_done at cycle 4 → stall_if/id/ex=1 and clear_ma=1 for cycles 0–3; cycle 4 releases. Trap in cycle 2 preempts: clears all, enters TRAP.
- Memory wait with redirect: dmem_busy=1 for 3 cycles concurrent with bj_en → all four stalls=1, no clears, flush_cnt unchanged. bj_en in the cycle after release → clear_id=clear_ex=1, flush_cnt+1.
- Counter saturation: preload stall_cnt to 2^CNT_W−1 via a small-CNT_W build (CNT_W=4), hold imem_busy → stall_cnt stays 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
//   state_e : controller FSM states
//   ctl_t   : the full set of per-stage stall/clear controls, driven as one unit
package pipe_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULTI = 2'd1,
        TRAP  = 2'd2
    } state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_ma;
        logic clear_id;
        logic clear_ex;
        logic clear_ma;
    } ctl_t;

    localparam int TRAP_HOLD_DEF = 2;

    localparam ctl_t CTL_NONE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : count this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_ctl.sv
// Central hazard and sequencing controller for the five-stage core.
// Generates the IF/ID, ID/EX and EX/MA stall/clear pairs from the current
// hazard inputs plus a small FSM (RUN / MULTI / TRAP), and keeps two
// saturating performance counters.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs1/rs2, *_used       : source registers of the ID instruction
//   ex_rd, ex_load           : destination / load flag of the EX instruction
//   ex_multi, ex_multi_done  : multi-cycle EX op present / result valid
//   bj_en, trap_en           : branch/jump or trap/xret redirect from EX
//   imem_busy, dmem_busy     : fetch / data-memory access outstanding
//   stall_* / clear_*        : per-stage hold / bubble controls (combinational)
//   stall_cnt                : cycles with stall_if high (registered)
//   flush_cnt                : redirects taken (registered)
module pipe_ctl
    import pipe_pkg::*;
#(
    parameter int TRAP_HOLD = TRAP_HOLD_DEF,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd,
    input  logic             ex_load,
    input  logic             ex_multi,
    input  logic             ex_multi_done,
    input  logic             bj_en,
    input  logic             trap_en,
    input  logic             imem_busy,
    input  logic             dmem_busy,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_ma,
    output logic             clear_id,
    output logic             clear_ex,
    output logic             clear_ma,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Width of the post-trap down-counter; kept at least one bit wide so a
    // TRAP_HOLD of 1 still elaborates.
    localparam int TC_W = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD) : 1;

    state_e          state_q;
    state_e          state_d;
    logic [TC_W-1:0] trap_cnt_q;
    logic [TC_W-1:0] trap_cnt_d;
    ctl_t            ctl;
    logic            load_use;
    logic            flush_inc;
    logic [1:0]      cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    // Load-use: the EX load writes a register the ID instruction reads. x0 is
    // never a real dependency.
    assign load_use = ex_load && (ex_rd != 5'd0) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) ||
                       (id_rs2_used && (id_rs2 == ex_rd)));

    always_comb begin
        ctl        = CTL_NONE;
        state_d    = state_q;
        trap_cnt_d = trap_cnt_q;
        flush_inc  = 1'b0;

        if (rst) begin
            ctl.clear_id = 1'b1;
            ctl.clear_ex = 1'b1;
            ctl.clear_ma = 1'b1;
            state_d      = RUN;
            trap_cnt_d   = '0;
        end else if (trap_en && (state_q != TRAP)) begin
            // Trap wins over everything, including an in-flight multi-cycle op.
            ctl.clear_id = 1'b1;
            ctl.clear_ex = 1'b1;
            ctl.clear_ma = 1'b1;
            state_d      = TRAP;
            trap_cnt_d   = TC_W'(TRAP_HOLD - 1);
            flush_inc    = 1'b1;
        end else if (state_q == TRAP) begin
            // Fetch held while the trap target settles; redirects ignored.
            ctl.stall_if = 1'b1;
            ctl.clear_id = 1'b1;
            if (trap_cnt_q == '0) begin
                state_d = RUN;
            end else begin
                trap_cnt_d = trap_cnt_q - TC_W'(1);
            end
        end else if (dmem_busy) begin
            // Whole pipe frozen; a pending bj_en is re-presented after release.
            ctl.stall_if = 1'b1;
            ctl.stall_id = 1'b1;
            ctl.stall_ex = 1'b1;
            ctl.stall_ma = 1'b1;
        end else if (bj_en && (state_q == RUN)) begin
            ctl.clear_id = 1'b1;
            ctl.clear_ex = 1'b1;
            flush_inc    = 1'b1;
        end else if ((state_q == MULTI) || ex_multi) begin
            // Done is only honoured once in MULTI, so the entry cycle always stalls.
            if ((state_q == MULTI) && ex_multi_done) begin
                state_d = RUN;
            end else begin
                ctl.stall_if = 1'b1;
                ctl.stall_id = 1'b1;
                ctl.stall_ex = 1'b1;
                ctl.clear_ma = 1'b1;
                state_d      = MULTI;
            end
        end else if (load_use) begin
            // The bubble into EX removes the load's dependency, so this lasts one cycle.
            ctl.stall_if = 1'b1;
            ctl.stall_id = 1'b1;
            ctl.clear_ex = 1'b1;
        end else if (imem_busy) begin
            ctl.stall_if = 1'b1;
            ctl.clear_id = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    assign stall_if = ctl.stall_if;
    assign stall_id = ctl.stall_id;
    assign stall_ex = ctl.stall_ex;
    assign stall_ma = ctl.stall_ma;
    assign clear_id = ctl.clear_id;
    assign clear_ex = ctl.clear_ex;
    assign clear_ma = ctl.clear_ma;

    // Index 0: stall cycles, index 1: redirects.
    assign cnt_inc[0] = ctl.stall_if & ~rst;
    assign cnt_inc[1] = flush_inc;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = cnt_val[0];
    assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_ctl.sv
// Directed bench for pipe_ctl. Each step drives inputs after a rising edge,
// pushes the expected control vector onto a scoreboard queue, and pops and
// compares it on the falling edge. A second instance with 4-bit counters
// shares the stimulus and is used for the saturation checks.
module tb_pipe_ctl;

    // Control vector order: {stall_if, stall_id, stall_ex, stall_ma, clear_id, clear_ex, clear_ma}
    localparam logic [6:0] C_NONE  = 7'b000_0000;
    localparam logic [6:0] C_CLR3  = 7'b000_0111;
    localparam logic [6:0] C_TRAPH = 7'b100_0100;
    localparam logic [6:0] C_IMEM  = 7'b100_0100;
    localparam logic [6:0] C_LU    = 7'b110_0010;
    localparam logic [6:0] C_MULTI = 7'b111_0001;
    localparam logic [6:0] C_DMEM  = 7'b111_1000;
    localparam logic [6:0] C_BJ    = 7'b000_0110;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_load, ex_multi, ex_multi_done;
    logic        bj_en, trap_en, imem_busy, dmem_busy;

    logic        stall_if, stall_id, stall_ex, stall_ma, clear_id, clear_ex, clear_ma;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_stall_if, s_stall_id, s_stall_ex, s_stall_ma, s_clear_id, s_clear_ex, s_clear_ma;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    logic [6:0]  ctl_obs;
    logic [6:0]  exp_q [$];
    string       tag_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    assign ctl_obs = {stall_if, stall_id, stall_ex, stall_ma, clear_id, clear_ex, clear_ma};

    always #5 clk = ~clk;

    pipe_ctl #(.TRAP_HOLD(2), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_multi(ex_multi), .ex_multi_done(ex_multi_done),
        .bj_en(bj_en), .trap_en(trap_en), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_ma(stall_ma),
        .clear_id(clear_id), .clear_ex(clear_ex), .clear_ma(clear_ma),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctl #(.TRAP_HOLD(2), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_load(ex_load), .ex_multi(ex_multi), .ex_multi_done(ex_multi_done),
        .bj_en(bj_en), .trap_en(trap_en), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
        .stall_if(s_stall_if), .stall_id(s_stall_id), .stall_ex(s_stall_ex), .stall_ma(s_stall_ma),
        .clear_id(s_clear_id), .clear_ex(s_clear_ex), .clear_ma(s_clear_ma),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic idle_inputs();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_load = 1'b0; ex_multi = 1'b0; ex_multi_done = 1'b0;
        bj_en = 1'b0; trap_en = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
    endtask

    // One clock of stimulus: inputs are already driven; expectation queued now,
    // checked at the falling edge, then advance past the next rising edge.
    task automatic apply(input string tag, input logic [6:0] exp);
        logic [6:0] e;
        string      t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        $display("[%0t] txn %s ctl=%b exp=%b", $time, t, ctl_obs, e);
        assert (ctl_obs === e) else begin
            miscompares++;
            $error("FAIL %s ctl observed=%b expected=%b", t, ctl_obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [31:0] exp_stall, input logic [31:0] exp_flush);
        vectors++;
        assert (stall_cnt === exp_stall) else begin
            miscompares++;
            $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_stall);
        end
        vectors++;
        assert (flush_cnt === exp_flush) else begin
            miscompares++;
            $error("FAIL %s flush_cnt observed=%0d expected=%0d", tag, flush_cnt, exp_flush);
        end
    endtask

    task automatic check_cnt_s(input string tag, input logic [3:0] exp_stall, input logic [3:0] exp_flush);
        vectors++;
        assert (s_stall_cnt === exp_stall) else begin
            miscompares++;
            $error("FAIL %s small stall_cnt observed=%0d expected=%0d", tag, s_stall_cnt, exp_stall);
        end
        vectors++;
        assert (s_flush_cnt === exp_flush) else begin
            miscompares++;
            $error("FAIL %s small flush_cnt observed=%0d expected=%0d", tag, s_flush_cnt, exp_flush);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;

        // Reset: all clears, no stalls; counters zero afterwards.
        apply("reset", C_CLR3);
        rst = 1'b0;
        check_cnt("after_reset", 32'd0, 32'd0);
        apply("idle", C_NONE);

        // Load-use on rs2, then the bubble leaves EX without the load.
        ex_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        apply("lu_rs2", C_LU);
        ex_load = 1'b0;
        apply("lu_after", C_NONE);
        check_cnt("lu_cnt", 32'd1, 32'd0);
        ex_load = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        apply("lu_x0", C_NONE);
        ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1; id_rs2_used = 1'b0;
        apply("lu_rs1", C_LU);
        id_rs1_used = 1'b0;
        apply("lu_rs1_unused", C_NONE);
        idle_inputs();
        check_cnt("lu_cnt2", 32'd2, 32'd0);

        // Trap redirect with a branch during the hold that must be ignored.
        trap_en = 1'b1;
        apply("trap_c0", C_CLR3);
        trap_en = 1'b0; bj_en = 1'b1;
        apply("trap_c1_bj", C_TRAPH);
        bj_en = 1'b0;
        apply("trap_c2", C_TRAPH);
        apply("trap_c3_run", C_NONE);
        check_cnt("trap_cnt", 32'd4, 32'd1);

        // Multi-cycle op; done on the entry cycle is ignored, release at cycle 4.
        ex_multi = 1'b1; ex_multi_done = 1'b1;
        apply("multi_c0", C_MULTI);
        ex_multi_done = 1'b0;
        apply("multi_c1", C_MULTI);
        apply("multi_c2", C_MULTI);
        apply("multi_c3", C_MULTI);
        ex_multi_done = 1'b1;
        apply("multi_c4_rel", C_NONE);
        idle_inputs();
        apply("multi_after", C_NONE);
        check_cnt("multi_cnt", 32'd8, 32'd1);

        // Trap preempts an in-flight multi-cycle op.
        ex_multi = 1'b1;
        apply("mtrap_c0", C_MULTI);
        apply("mtrap_c1", C_MULTI);
        trap_en = 1'b1;
        apply("mtrap_c2", C_CLR3);
        idle_inputs();
        apply("mtrap_h1", C_TRAPH);
        apply("mtrap_h2", C_TRAPH);
        apply("mtrap_run", C_NONE);
        check_cnt("mtrap_cnt", 32'd12, 32'd2);

        // Memory wait concurrent with a branch: branch not acted on until release.
        dmem_busy = 1'b1; bj_en = 1'b1;
        apply("dmem_c0", C_DMEM);
        apply("dmem_c1", C_DMEM);
        apply("dmem_c2", C_DMEM);
        check_cnt("dmem_cnt", 32'd15, 32'd2);
        dmem_busy = 1'b0;
        apply("dmem_bj", C_BJ);
        bj_en = 1'b0;
        apply("dmem_after", C_NONE);
        check_cnt("dmem_bj_cnt", 32'd15, 32'd3);

        // Memory wait inside MULTI keeps MULTI, so done afterwards releases.
        ex_multi = 1'b1;
        apply("dm_multi_entry", C_MULTI);
        dmem_busy = 1'b1; ex_multi_done = 1'b1;
        apply("dm_multi_wait", C_DMEM);
        dmem_busy = 1'b0;
        apply("dm_multi_rel", C_NONE);
        idle_inputs();
        apply("dm_multi_after", C_NONE);
        check_cnt("dm_multi_cnt", 32'd17, 32'd3);

        // Fetch wait, and its priority against branch and load-use.
        imem_busy = 1'b1;
        apply("imem", C_IMEM);
        bj_en = 1'b1;
        apply("imem_bj", C_BJ);
        bj_en = 1'b0; ex_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        apply("imem_lu", C_LU);
        idle_inputs();
        apply("imem_after", C_NONE);
        check_cnt("imem_cnt", 32'd19, 32'd4);

        // Reset while in TRAP with trap_cnt=1: no residual hold afterwards.
        trap_en = 1'b1;
        apply("rtrap_c0", C_CLR3);
        trap_en = 1'b0; rst = 1'b1;
        apply("rtrap_rst", C_CLR3);
        rst = 1'b0;
        apply("rtrap_run", C_NONE);
        check_cnt("rtrap_cnt", 32'd0, 32'd0);
        check_cnt_s("rtrap_cnt", 4'd0, 4'd0);

        // Saturation: 4-bit counters stick at 15, 32-bit ones keep counting.
        imem_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply($sformatf("sat_imem_%0d", i), C_IMEM);
        end
        imem_busy = 1'b0;
        check_cnt("sat_stall", 32'd20, 32'd0);
        check_cnt_s("sat_stall", 4'd15, 4'd0);
        bj_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            apply($sformatf("sat_bj_%0d", i), C_BJ);
        end
        bj_en = 1'b0;
        check_cnt("sat_flush", 32'd20, 32'd17);
        check_cnt_s("sat_flush", 4'd15, 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
